// File: rtl/gray_sync_decoder.sv
// Receive stage for a Gray-coded count from another clock region: synchronise,
// validate single-bit steps, decode to binary, and resynchronise after illegal jumps.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             en,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             dir_up,
  output logic             wrap,
  output logic             step_err,
  output logic [7:0]       err_count
);

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {FILL, TRACK, RESYNC} state_t;

  state_t                             state;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
  logic [WIDTH-1:0]                   gs;
  logic [WIDTH-1:0]                   gs_prev;
  logic [WIDTH-1:0]                   gp;
  logic [FW-1:0]                      fill_cnt;
  logic [SW-1:0]                      stable_cnt;
  logic [WIDTH-1:0]                   dec_gs;
  logic [WIDTH-1:0]                   dec_gp;
  logic [WIDTH-1:0]                   diff;
  logic                               one_bit;
  logic                               multi_bit;
  logic                               step_up;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The synchroniser runs regardless of en so that a resumed FSM sees current data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
    end
  end

  assign gs     = sync_q[SYNC_STAGES-1];
  assign dec_gs = gray2bin(gs);
  assign dec_gp = gray2bin(gp);
  assign diff   = gs ^ gp;

  // A power-of-two difference means exactly one bit changed.
  assign one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign multi_bit = (diff != '0) && !one_bit;
  assign step_up   = (dec_gs == dec_gp + WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      gs_prev    <= '0;
      gp         <= '0;
      fill_cnt   <= '0;
      stable_cnt <= '0;
      bin_out    <= '0;
      bin_valid  <= 1'b0;
      dir_up     <= 1'b1;
      wrap       <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      gs_prev   <= gs;
      bin_valid <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      if (en) begin
        case (state)
          FILL: begin
            if (fill_cnt == FW'(SYNC_STAGES - 1)) begin
              gp      <= gs;
              bin_out <= dec_gs;
              state   <= TRACK;
            end else begin
              fill_cnt <= fill_cnt + FW'(1);
            end
          end
          TRACK: begin
            if (one_bit) begin
              gp        <= gs;
              bin_out   <= dec_gs;
              bin_valid <= 1'b1;
              dir_up    <= step_up;
              wrap      <= step_up ? (dec_gs == '0) : (dec_gs == '1);
            end else if (multi_bit) begin
              step_err   <= 1'b1;
              stable_cnt <= '0;
              state      <= RESYNC;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
            end
          end
          RESYNC: begin
            // Leave only after STABLE_CYC consecutive unchanged samples.
            if (gs == gs_prev) begin
              if (stable_cnt == SW'(STABLE_CYC - 1)) begin
                gp         <= gs;
                bin_out    <= dec_gs;
                bin_valid  <= 1'b1;
                stable_cnt <= '0;
                state      <= TRACK;
              end else begin
                stable_cnt <= stable_cnt + SW'(1);
              end
            end else begin
              stable_cnt <= '0;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder: stepping, wrap, illegal jumps, resync,
// async reset, error saturation and enable freeze.
module tb_gray_sync_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       en;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       dir_up;
  logic       wrap;
  logic       step_err;
  logic [7:0] err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;

  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                            4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(2), .STABLE_CYC(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .en        (en),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .dir_up    (dir_up),
    .wrap      (wrap),
    .step_err  (step_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; tally pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bin_valid) n_valid++;
    if (step_err) n_err++;
  endtask

  // Drive one legal Gray step and check latency, value, direction and wrap.
  task automatic step_to(input int v, input int prev, input int up, input int w);
    gray_in = gtab[v];
    tick();
    tick();
    chk("latency_hold", bin_out, prev);
    chk("latency_novalid", bin_valid, 0);
    tick();
    chk("step_value", bin_out, v);
    chk("step_valid", bin_valid, 1);
    chk("step_dir", dir_up, up);
    chk("step_wrap", wrap, w);
    $display("step gray=%b -> bin_out=%0d valid=%0b dir_up=%0b wrap=%0b",
             gtab[v], bin_out, bin_valid, dir_up, wrap);
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b1;
    gray_in = 4'b0000;

    // Reset values while reset is held
    #12;
    chk("rst_bin_out", bin_out, 0);
    chk("rst_valid", bin_valid, 0);
    chk("rst_dir_up", dir_up, 1);
    chk("rst_wrap", wrap, 0);
    chk("rst_step_err", step_err, 0);
    chk("rst_err_count", err_count, 0);

    // Release and idle through FILL
    tick();
    rst_n = 1'b1;
    n_valid = 0;
    n_err = 0;
    repeat (10) tick();
    chk("fill_no_valid", n_valid, 0);
    chk("fill_bin_out", bin_out, 0);
    chk("fill_err_count", err_count, 0);
    $display("fill done bin_out=%0d err_count=%0d", bin_out, err_count);

    // Count up through the full range and wrap 15 -> 0
    for (int v = 1; v <= 16; v++) begin
      step_to(v % 16, v - 1, 1, (v == 16) ? 1 : 0);
    end

    // Up to 3, then down 2,1,0,15 with wrap on 0 -> 15
    step_to(1, 0, 1, 0);
    step_to(2, 1, 1, 0);
    step_to(3, 2, 1, 0);
    step_to(2, 3, 0, 0);
    step_to(1, 2, 0, 0);
    step_to(0, 1, 0, 0);
    step_to(15, 0, 0, 1);

    // Climb to 5, then an illegal two-bit jump 0111 -> 0100
    step_to(0, 15, 1, 1);
    for (int v = 1; v <= 5; v++) step_to(v, v - 1, 1, 0);
    gray_in = 4'b0100;
    tick(); tick(); tick();
    chk("jump_step_err", step_err, 1);
    chk("jump_err_count", err_count, 1);
    chk("jump_bin_held", bin_out, 5);
    chk("jump_no_valid", bin_valid, 0);
    $display("jump gray=0100 step_err=%0b err_count=%0d bin_out=%0d", step_err, err_count, bin_out);
    tick();
    chk("jump_err_pulse_end", step_err, 0);
    tick();
    chk("resync_wait_valid", bin_valid, 0);
    chk("resync_wait_bin", bin_out, 5);
    tick();
    chk("resync_exit_bin", bin_out, 7);
    chk("resync_exit_valid", bin_valid, 1);
    chk("resync_exit_wrap", wrap, 0);
    chk("resync_exit_dir", dir_up, 1);
    $display("resync exit bin_out=%0d valid=%0b wrap=%0b", bin_out, bin_valid, wrap);
    tick(); tick();

    // Enter RESYNC again, then keep the input unstable
    gray_in = 4'b0001;
    tick(); tick(); tick();
    chk("jump2_step_err", step_err, 1);
    chk("jump2_err_count", err_count, 2);
    n_valid = 0;
    n_err = 0;
    for (int k = 0; k < 6; k++) begin
      gray_in = gray_in ^ 4'b0001;
      tick();
      tick();
    end
    chk("toggle_no_valid", n_valid, 0);
    chk("toggle_no_err", n_err, 0);
    chk("toggle_bin_held", bin_out, 7);
    $display("toggling in resync valid=%0d errs=%0d bin_out=%0d", n_valid, n_err, bin_out);

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_bin_out", bin_out, 0);
    chk("arst_err_count", err_count, 0);
    chk("arst_dir_up", dir_up, 1);
    chk("arst_valid", bin_valid, 0);
    chk("arst_step_err", step_err, 0);
    $display("async reset bin_out=%0d err_count=%0d", bin_out, err_count);

    // 260 illegal jumps, each allowed to resync
    gray_in = 4'b0000;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_valid = 0;
    n_err = 0;
    for (int i = 0; i < 260; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0011 : 4'b0000;
      repeat (8) tick();
    end
    chk("sat_err_pulses", n_err, 260);
    chk("sat_resync_valids", n_valid, 260);
    chk("sat_err_count", err_count, 255);
    chk("sat_bin_out", bin_out, 0);
    $display("saturation errs=%0d err_count=%0d", n_err, err_count);

    // Freeze with en=0 while the input moves two steps
    en = 1'b0;
    n_valid = 0;
    n_err = 0;
    gray_in = 4'b0001;
    repeat (4) tick();
    gray_in = 4'b0011;
    repeat (4) tick();
    chk("frozen_no_valid", n_valid, 0);
    chk("frozen_no_err", n_err, 0);
    chk("frozen_bin_out", bin_out, 0);
    en = 1'b1;
    tick();
    chk("resume_step_err", step_err, 1);
    chk("resume_err_sat", err_count, 255);
    chk("resume_bin_held", bin_out, 0);
    $display("resume vs frozen gp step_err=%0b bin_out=%0d", step_err, bin_out);
    repeat (6) tick();
    chk("resume_resync_bin", bin_out, 2);

    // Single step while frozen is accepted on resume
    en = 1'b0;
    gray_in = 4'b0010;
    repeat (4) tick();
    chk("frozen2_bin_out", bin_out, 2);
    en = 1'b1;
    tick();
    chk("resume2_valid", bin_valid, 1);
    chk("resume2_bin_out", bin_out, 3);
    chk("resume2_dir", dir_up, 1);
    $display("resume single step bin_out=%0d valid=%0b dir_up=%0b", bin_out, bin_valid, dir_up);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
